// File: rtl/rmc_pkg.sv
// Shared types and constants for the row-matrix scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rmc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        RESULT = 3'd3,
        DONEST = 3'd4
    } state_t;

    // Stages from an element handshake to its accumulate: one BRAM read cycle,
    // one DSP operand register stage, one product register stage.
    localparam int DSP_PIPE_DEPTH = 3;
    localparam int BRAM_RD_LAT    = 1;

    // Counter / index width that stays legal when the count is 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rmc_valid_pipe.sv
// Tracks issued elements through the DSP pipeline: v = real element, f = first of row.
// Latency: DEPTH cycles from in_v/in_f to out_v/out_f.
// Backpressure: none; shifts every cycle.
//   clk, rst_n    : clock, async active-low reset (clears all stages)
//   in_v, in_f    : element issued this cycle / it is element 0 of its row
//   out_v, out_f  : element reaching the accumulate stage this cycle
//   empty         : no element upstream of the final stage, so the pipe is
//                   empty from the next cycle on
module rmc_valid_pipe
    import rmc_pkg::*;
#(
    parameter int DEPTH = DSP_PIPE_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_v,
    input  logic in_f,
    output logic out_v,
    output logic out_f,
    output logic empty
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] f_q, f_d;

    always_comb begin
        v_d = {v_q[DEPTH-2:0], in_v};
        f_d = {f_q[DEPTH-2:0], in_f};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            f_q <= '0;
        end else begin
            v_q <= v_d;
            f_q <= f_d;
        end
    end

    assign out_v = v_q[DEPTH-1];
    assign out_f = f_q[DEPTH-1];
    // Looking one stage early lets the scheduler leave DRAIN in the same
    // cycle the final accumulate happens, so the result is visible next cycle.
    assign empty = ~|v_q[DEPTH-2:0];

endmodule

// File: rtl/rmc_row_scheduler.sv
// Multi-row sequencer for the weight-BRAM / DSP-MAC datapath; runs N_ROWS rows per START.
// Latency: handshake t -> accumulate t+3; last element t -> RES_VALID t+4; row period OP1_COL+4.
// Backpressure: IN_READY only in ISSUE; RES_VALID held until RES_READY, next row waits for it.
//   CLK, RSTN            : clock, async active-low reset
//   START, WBASE         : job start (IDLE only), weight base address latched with it
//   IN_VALID/READY/DATA  : input element stream
//   OP1_OUT              : registered operand broadcast to all DSP lanes
//   BRAM_ADDR, BRAM_RD_EN: weight read port (combinational in the handshake cycle)
//   DSP_EN/ACC_EN/ACC_LOAD: DSP pipeline enable, accumulate, load-instead-of-add
//   RES_VALID/RES_READY  : finished-row handshake; ROW_IDX current row; DONE job pulse
module rmc_row_scheduler
    import rmc_pkg::*;
#(
    parameter  int OP1_COL    = 4,
    parameter  int N_ROWS     = 8,
    parameter  int OP1_WIDTH  = 8,
    parameter  int BRAM_DEPTH = 64,
    localparam int AW         = $clog2(BRAM_DEPTH),
    localparam int RW         = clog2_min1(N_ROWS),
    localparam int EW         = clog2_min1(OP1_COL)
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        START,
    input  logic [AW-1:0]               WBASE,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic signed [OP1_WIDTH-1:0] IN_DATA,
    output logic [OP1_WIDTH-1:0]        OP1_OUT,
    output logic [AW-1:0]               BRAM_ADDR,
    output logic                        BRAM_RD_EN,
    output logic                        DSP_EN,
    output logic                        DSP_ACC_EN,
    output logic                        DSP_ACC_LOAD,
    output logic                        RES_VALID,
    input  logic                        RES_READY,
    output logic [RW-1:0]               ROW_IDX,
    output logic                        DONE
);

    state_t               state_q, state_d;
    logic [EW-1:0]        elem_cnt_q, elem_cnt_d;
    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [AW-1:0]        wbase_q, wbase_d;
    logic [OP1_WIDTH-1:0] op1_q, op1_d;
    // Low for the first edge after reset release, so a START that arrives
    // together with the release is not taken.
    logic                 arm_q, arm_d;

    logic hs;
    logic last_elem;
    logic last_row;
    logic pipe_v;
    logic pipe_f;
    logic pipe_empty;

    assign hs        = (state_q == ISSUE) && IN_VALID;
    assign last_elem = (elem_cnt_q == EW'(OP1_COL - 1));
    assign last_row  = (row_cnt_q == RW'(N_ROWS - 1));

    // BRAM depth is a power of two, so the AW-bit sum wraps modulo the depth.
    assign BRAM_ADDR = wbase_q + AW'(elem_cnt_q);

    rmc_valid_pipe #(
        .DEPTH (DSP_PIPE_DEPTH)
    ) u_valid_pipe (
        .clk   (CLK),
        .rst_n (RSTN),
        .in_v  (hs),
        .in_f  (hs && (elem_cnt_q == '0)),
        .out_v (pipe_v),
        .out_f (pipe_f),
        .empty (pipe_empty)
    );

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        row_cnt_d  = row_cnt_q;
        wbase_d    = wbase_q;
        op1_d      = op1_q;
        arm_d      = 1'b1;
        IN_READY   = 1'b0;
        BRAM_RD_EN = 1'b0;
        DSP_EN     = 1'b0;
        RES_VALID  = 1'b0;
        DONE       = 1'b0;

        case (state_q)
            IDLE: begin
                if (START && arm_q) begin
                    state_d    = ISSUE;
                    elem_cnt_d = '0;
                    row_cnt_d  = '0;
                    wbase_d    = WBASE;
                end
            end
            ISSUE: begin
                IN_READY = 1'b1;
                DSP_EN   = 1'b1;
                if (IN_VALID) begin
                    BRAM_RD_EN = 1'b1;
                    op1_d      = IN_DATA;
                    if (last_elem) begin
                        elem_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                DSP_EN = 1'b1;
                if (pipe_empty) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                RES_VALID = 1'b1;
                if (RES_READY) begin
                    if (last_row) begin
                        state_d = DONEST;
                    end else begin
                        row_cnt_d  = row_cnt_q + 1'b1;
                        elem_cnt_d = '0;
                        state_d    = ISSUE;
                    end
                end
            end
            DONEST: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            row_cnt_q  <= '0;
            wbase_q    <= '0;
            op1_q      <= '0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            row_cnt_q  <= row_cnt_d;
            wbase_q    <= wbase_d;
            op1_q      <= op1_d;
            arm_q      <= arm_d;
        end
    end

    assign OP1_OUT      = op1_q;
    assign ROW_IDX      = row_cnt_q;
    assign DSP_ACC_EN   = pipe_v;
    // The first element of every row overwrites whatever the accumulator held.
    assign DSP_ACC_LOAD = pipe_v && pipe_f;

endmodule

// File: tb/tb_rmc_row_scheduler.sv
// Randomized scoreboard bench: BRAM + 4-lane DSP plant driven by the DUT controls,
// expected row results are vector-matrix dot products computed at job start.
// Backpressure on RES_READY is tied-high, randomized, or a fixed 5-cycle stall.
module tb_rmc_row_scheduler;

    localparam int OP1_COL    = 4;
    localparam int N_ROWS     = 8;
    localparam int OP1_WIDTH  = 8;
    localparam int BRAM_DEPTH = 64;
    localparam int AW         = 6;
    localparam int RW         = 3;
    localparam int LANES      = 4;

    logic                        CLK;
    logic                        RSTN;
    logic                        START;
    logic [AW-1:0]               WBASE;
    logic                        IN_VALID;
    logic                        IN_READY;
    logic signed [OP1_WIDTH-1:0] IN_DATA;
    logic [OP1_WIDTH-1:0]        OP1_OUT;
    logic [AW-1:0]               BRAM_ADDR;
    logic                        BRAM_RD_EN;
    logic                        DSP_EN;
    logic                        DSP_ACC_EN;
    logic                        DSP_ACC_LOAD;
    logic                        RES_VALID;
    logic                        RES_READY;
    logic [RW-1:0]               ROW_IDX;
    logic                        DONE;

    rmc_row_scheduler #(
        .OP1_COL    (OP1_COL),
        .N_ROWS     (N_ROWS),
        .OP1_WIDTH  (OP1_WIDTH),
        .BRAM_DEPTH (BRAM_DEPTH)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .START        (START),
        .WBASE        (WBASE),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_DATA      (IN_DATA),
        .OP1_OUT      (OP1_OUT),
        .BRAM_ADDR    (BRAM_ADDR),
        .BRAM_RD_EN   (BRAM_RD_EN),
        .DSP_EN       (DSP_EN),
        .DSP_ACC_EN   (DSP_ACC_EN),
        .DSP_ACC_LOAD (DSP_ACC_LOAD),
        .RES_VALID    (RES_VALID),
        .RES_READY    (RES_READY),
        .ROW_IDX      (ROW_IDX),
        .DONE         (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // ---------------- datapath plant: weight BRAM + DSP lanes ----------------
    logic signed [7:0]  mem [BRAM_DEPTH][LANES];
    logic signed [7:0]  bram_q [LANES];
    logic signed [7:0]  b_q [LANES];
    logic signed [7:0]  a_q;
    logic signed [31:0] prod [LANES];
    logic signed [31:0] acc [LANES];
    logic [AW-1:0]      s_addr;
    logic               s_rd, s_en, s_acc, s_ld;
    logic signed [7:0]  s_op1;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int l = 0; l < LANES; l++) begin
            if (s_rd) bram_q[l] <= mem[s_addr][l];
            if (s_en) begin
                b_q[l]  <= bram_q[l];
                prod[l] <= a_q * b_q[l];
            end
            if (s_acc) acc[l] <= s_ld ? prod[l] : acc[l] + prod[l];
        end
        if (s_en) a_q <= s_op1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]            row;
        logic [LANES-1:0][31:0] res;
    } exp_t;

    exp_t exp_q [$];
    int   hs_q [$];
    bit   first_q [$];
    exp_t e;
    bit   exp_acc;
    int   elem_k = 0;
    int   last_hs = 0;
    int   last_acc = 0;
    int   row_first_hs = -1;
    bit   res_seen = 0;
    int   res_len = 0;
    bit   follow = 0;
    int   follow_row = 0;
    int   done_cnt = 0;
    int   job_wbase = 0;
    int   exp_hold = 0;
    bit   strict = 0;
    int   rr_mode = 0;
    int   low_cnt = 0;

    always @(negedge CLK) begin
        s_addr = BRAM_ADDR;
        s_rd   = BRAM_RD_EN;
        s_en   = DSP_EN;
        s_acc  = DSP_ACC_EN;
        s_ld   = DSP_ACC_LOAD;
        s_op1  = OP1_OUT;
        if (RSTN) begin
            exp_acc = (hs_q.size() > 0) && (hs_q[0] + 3 == cyc);
            if (exp_acc || DSP_ACC_EN)
                check(DSP_ACC_EN == exp_acc, "acc_en_timing", DSP_ACC_EN, exp_acc);
            if (exp_acc && DSP_ACC_EN)
                check(DSP_ACC_LOAD == first_q[0], "acc_load", DSP_ACC_LOAD, first_q[0]);
            if (exp_acc) begin
                void'(hs_q.pop_front());
                void'(first_q.pop_front());
            end

            if (follow) begin
                follow = 0;
                if (follow_row == N_ROWS - 1) begin
                    check(DONE == 1'b1, "done_after_last", DONE, 1);
                end else begin
                    check(IN_READY == 1'b1, "ready_after_accept", IN_READY, 1);
                    check(int'(ROW_IDX) == follow_row + 1, "row_idx_next", ROW_IDX, follow_row + 1);
                end
            end

            if (IN_READY && IN_VALID) begin
                check(BRAM_RD_EN == 1'b1, "rd_en_hs", BRAM_RD_EN, 1);
                check(int'(BRAM_ADDR) == (job_wbase + elem_k) % BRAM_DEPTH, "bram_addr",
                      BRAM_ADDR, (job_wbase + elem_k) % BRAM_DEPTH);
                if (elem_k == 0) begin
                    if (strict && row_first_hs >= 0)
                        check(cyc - row_first_hs == OP1_COL + 4, "row_period", cyc - row_first_hs, OP1_COL + 4);
                    row_first_hs = cyc;
                end
                hs_q.push_back(cyc);
                first_q.push_back(elem_k == 0);
                last_hs = cyc;
                elem_k++;
            end else if (IN_READY) begin
                check(BRAM_RD_EN == 1'b0, "rd_en_bubble", BRAM_RD_EN, 0);
            end

            if (RES_VALID) begin
                if (!res_seen) begin
                    res_seen = 1;
                    res_len  = 0;
                    check(cyc == last_hs + 4, "res_latency", cyc - last_hs, 4);
                    check(IN_READY == 1'b0, "ready_low_in_result", IN_READY, 0);
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_result", ROW_IDX, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(int'(ROW_IDX) == int'(e.row), "res_row_idx", ROW_IDX, e.row);
                        for (int l = 0; l < LANES; l++)
                            check(acc[l] == $signed(e.res[l]), "res_lane", acc[l], $signed(e.res[l]));
                    end
                end
                res_len++;
                if (RES_READY) begin
                    if (exp_hold > 0 && ROW_IDX == 0)
                        check(res_len == exp_hold, "res_hold_len", res_len, exp_hold);
                    follow     = 1;
                    follow_row = int'(ROW_IDX);
                    res_seen   = 0;
                    elem_k     = 0;
                    last_acc   = cyc;
                end
            end

            if (DONE) begin
                check(cyc == last_acc + 1, "done_timing", cyc - last_acc, 1);
                done_cnt++;
                row_first_hs = -1;
            end
        end
    end

    // ---------------- RES_READY driver ----------------
    initial begin
        RES_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rr_mode)
                0: RES_READY = 1'b1;
                1: RES_READY = ($urandom_range(0, 2) == 0);
                default: begin
                    if (RES_VALID && ROW_IDX == 0 && low_cnt < 5) begin
                        RES_READY = 1'b0;
                        low_cnt++;
                    end else begin
                        RES_READY = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic signed [7:0] xs [N_ROWS][OP1_COL];

    function automatic void check_zero(input string tag);
        check(IN_READY == 0,     {tag, "_in_ready"},  IN_READY, 0);
        check(OP1_OUT == 0,      {tag, "_op1_out"},   OP1_OUT, 0);
        check(BRAM_ADDR == 0,    {tag, "_bram_addr"}, BRAM_ADDR, 0);
        check(BRAM_RD_EN == 0,   {tag, "_rd_en"},     BRAM_RD_EN, 0);
        check(DSP_EN == 0,       {tag, "_dsp_en"},    DSP_EN, 0);
        check(DSP_ACC_EN == 0,   {tag, "_acc_en"},    DSP_ACC_EN, 0);
        check(DSP_ACC_LOAD == 0, {tag, "_acc_load"},  DSP_ACC_LOAD, 0);
        check(RES_VALID == 0,    {tag, "_res_valid"}, RES_VALID, 0);
        check(ROW_IDX == 0,      {tag, "_row_idx"},   ROW_IDX, 0);
        check(DONE == 0,         {tag, "_done"},      DONE, 0);
    endfunction

    task automatic send_elem(input logic signed [7:0] x, input bit bub, input bit noise);
        bit got = 0;
        bit v;
        for (int i = 0; i < 300 && !got; i++) begin
            v = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
            IN_VALID = v;
            IN_DATA  = v ? x : 8'($urandom);
            if (noise) begin
                START = ($urandom_range(0, 7) == 0);
                WBASE = 6'($urandom);
            end
            @(negedge CLK);
            got = IN_VALID && IN_READY;
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        if (!got) check(0, "send_timeout", 0, 1);
    endtask

    task automatic start_pulse(input int wb);
        @(posedge CLK);
        #1;
        START = 1'b1;
        WBASE = AW'(wb);
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic run_job(input int wb, input bit bub, input int rr, input bit noise,
                           input int hold, input bit st);
        int   d0;
        exp_t ex;
        longint s;
        for (int r = 0; r < N_ROWS; r++)
            for (int k = 0; k < OP1_COL; k++)
                xs[r][k] = 8'($urandom);
        for (int r = 0; r < N_ROWS; r++) begin
            ex.row = 32'(r);
            for (int l = 0; l < LANES; l++) begin
                s = 0;
                for (int k = 0; k < OP1_COL; k++)
                    s += longint'(xs[r][k]) * longint'(mem[(wb + k) % BRAM_DEPTH][l]);
                ex.res[l] = 32'(s);
            end
            exp_q.push_back(ex);
        end
        job_wbase = wb;
        rr_mode   = rr;
        exp_hold  = hold;
        strict    = st;
        low_cnt   = 0;
        d0        = done_cnt;
        start_pulse(wb);
        for (int r = 0; r < N_ROWS; r++)
            for (int k = 0; k < OP1_COL; k++)
                send_elem(xs[r][k], bub, noise);
        IN_VALID = 1'b0;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge CLK);
        check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
        repeat (10) @(posedge CLK);
        #1;
        check(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
        check(exp_q.size() == 0, "results_drained", exp_q.size(), 0);
        exp_q.delete();
        rr_mode  = 0;
        exp_hold = 0;
        strict   = 0;
    endtask

    initial begin
        RSTN     = 1'b0;
        START    = 1'b0;
        WBASE    = '0;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        for (int a = 0; a < BRAM_DEPTH; a++)
            for (int l = 0; l < LANES; l++)
                mem[a][l] = 8'($urandom);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (2) @(posedge CLK);

        run_job(0, 0, 0, 0, 0, 1);            // steady stream, exact timing
        run_job(62, 1, 0, 0, 0, 0);           // address wrap with bubbles
        run_job($urandom_range(0, 63), 0, 2, 0, 6, 0);  // 5-cycle result stall on row 0
        run_job($urandom_range(0, 63), 1, 1, 1, 0, 0);  // random backpressure + START noise

        // Reset mid-row after two handshakes.
        job_wbase = 10;
        start_pulse(10);
        send_elem(8'sd17, 0, 0);
        send_elem(-8'sd5, 0, 0);
        RSTN = 1'b0;
        #1;
        check_zero("midrow_reset");
        hs_q.delete();
        first_q.delete();
        exp_q.delete();
        elem_k = 0;
        res_seen = 0;
        follow = 0;
        row_first_hs = -1;
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        // START presented in the same cycle reset is released.
        RSTN  = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check(IN_READY == 1'b0, "start_at_reset_release", IN_READY, 0);
        repeat (2) @(posedge CLK);

        run_job(33, 1, 1, 0, 0, 0);
        for (int j = 0; j < 3; j++)
            run_job($urandom_range(0, 63), 1, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
